// File: rtl/ir_cmd_scheduler_pkg.sv
// Shared definitions for the channel-command scheduler: default command codes,
// issuer state encoding and drop-counter width/saturation.
package ir_cmd_scheduler_pkg;

    localparam logic [7:0] CMD_POWER    = 8'h80;
    localparam logic [7:0] CMD_CH_PLUS  = 8'h18;
    localparam logic [7:0] CMD_CH_MINUS = 8'h38;

    localparam int DROP_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        GAP   = 2'b10
    } state_e;

    // Up to four requests can be rejected in one cycle, so the add saturates.
    function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] cnt,
                                                       input logic [2:0]        inc);
        logic [DROP_W:0] sum;
        sum = {1'b0, cnt} + {{(DROP_W-2){1'b0}}, inc};
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; push and pop in the same cycle are both honoured.
module cmd_fifo
    import ir_cmd_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Arbitrates IR and front-panel commands into a FIFO and issues them with a
// minimum idle gap. Define IR_CMD_REPEAT_EN to honour IR repeat frames.
module ir_cmd_scheduler
    import ir_cmd_scheduler_pkg::*;
#(
    parameter int         FIFO_DEPTH    = 4,
    parameter int         GAP_CYCLES    = 1000,
    parameter logic [7:0] CODE_POWER    = CMD_POWER,
    parameter logic [7:0] CODE_CH_PLUS  = CMD_CH_PLUS,
    parameter logic [7:0] CODE_CH_MINUS = CMD_CH_MINUS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        ir_cmd,
    input  logic              ir_valid,
    input  logic              ir_repeat,
    input  logic              btn_power,
    input  logic              btn_ch_plus,
    input  logic              btn_ch_minus,
    output logic [7:0]        cmd_out,
    output logic              cmd_valid,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int                CNT_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    logic              pan_vld_q, pan_vld_d, ir_vld_q, ir_vld_d;
    logic [7:0]        pan_cmd_q, pan_cmd_d, ir_cmd_q, ir_cmd_d;
    logic              rr_ir_q, rr_ir_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              pan_req, ir_req, gnt_pan, gnt_ir;
    logic [7:0]        pan_code, ir_code;
    logic [1:0]        pan_lost;
    logic [2:0]        drop_inc;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_din, fifo_dout;
    state_e            state_q;
    logic [7:0]        cmd_out_q;
    logic              cmd_valid_q;
    logic [CNT_W-1:0]  gap_cnt_q;

    // Simultaneous panel pulses: highest priority wins, the rest are rejected.
    always_comb begin
        pan_req  = btn_power | btn_ch_plus | btn_ch_minus;
        pan_code = btn_power ? CODE_POWER : (btn_ch_plus ? CODE_CH_PLUS : CODE_CH_MINUS);
        pan_lost = btn_power ? ({1'b0, btn_ch_plus} + {1'b0, btn_ch_minus})
                             : {1'b0, btn_ch_plus & btn_ch_minus};
    end

`ifdef IR_CMD_REPEAT_EN
    logic [7:0] last_ir_q, last_ir_d;
    logic       rep_ok;

    // Only channel stepping auto-repeats; a held POWER key must not toggle.
    always_comb begin
        rep_ok    = ir_repeat && !ir_valid &&
                    ((last_ir_q == CODE_CH_PLUS) || (last_ir_q == CODE_CH_MINUS));
        ir_req    = ir_valid || rep_ok;
        ir_code   = ir_valid ? ir_cmd : last_ir_q;
        last_ir_d = ir_valid ? ir_cmd : last_ir_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_ir_q <= 8'h00;
        else        last_ir_q <= last_ir_d;
    end
`else
    logic unused_ir_repeat;

    assign unused_ir_repeat = ir_repeat;
    assign ir_req           = ir_valid;
    assign ir_code          = ir_cmd;
`endif

    always_comb begin
        gnt_pan = 1'b0;
        gnt_ir  = 1'b0;
        if (!fifo_full) begin
            if (pan_vld_q && (!ir_vld_q || !rr_ir_q)) gnt_pan = 1'b1;
            else if (ir_vld_q)                        gnt_ir  = 1'b1;
        end
        rr_ir_d = rr_ir_q;
        if (gnt_pan)     rr_ir_d = 1'b1;
        else if (gnt_ir) rr_ir_d = 1'b0;

        // A register emptied by this cycle's grant still rejects a new request.
        pan_vld_d = pan_vld_q & ~gnt_pan;
        pan_cmd_d = pan_cmd_q;
        if (pan_req && !pan_vld_q) begin
            pan_vld_d = 1'b1;
            pan_cmd_d = pan_code;
        end
        ir_vld_d = ir_vld_q & ~gnt_ir;
        ir_cmd_d = ir_cmd_q;
        if (ir_req && !ir_vld_q) begin
            ir_vld_d = 1'b1;
            ir_cmd_d = ir_code;
        end

        drop_inc   = {1'b0, pan_lost} + {2'b00, pan_req & pan_vld_q} + {2'b00, ir_req & ir_vld_q};
        drop_cnt_d = drop_sat_add(drop_cnt_q, drop_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pan_vld_q  <= 1'b0;
            pan_cmd_q  <= 8'h00;
            ir_vld_q   <= 1'b0;
            ir_cmd_q   <= 8'h00;
            rr_ir_q    <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pan_vld_q  <= pan_vld_d;
            pan_cmd_q  <= pan_cmd_d;
            ir_vld_q   <= ir_vld_d;
            ir_cmd_q   <= ir_cmd_d;
            rr_ir_q    <= rr_ir_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fifo_push = gnt_pan | gnt_ir;
    assign fifo_din  = gnt_ir ? ir_cmd_q : pan_cmd_q;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_out_q   <= 8'h00;
            cmd_valid_q <= 1'b0;
            gap_cnt_q   <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        cmd_out_q   <= fifo_dout;
                        cmd_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    gap_cnt_q <= '0;
                    state_q   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) state_q   <= IDLE;
                    else                       gap_cnt_q <= gap_cnt_q + CNT_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_out   = cmd_out_q;
    assign cmd_valid = cmd_valid_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = pan_vld_q | ir_vld_q | !fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Scoreboard bench for ir_cmd_scheduler: dut_a (gap 4) for most scenarios,
// dut_b (gap 100) for the FIFO-overflow scenario.
module tb_ir_cmd_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ir_cmd = 8'h00;
    logic       ir_valid = 1'b0, ir_repeat = 1'b0;
    logic       btn_power = 1'b0, btn_ch_plus = 1'b0, btn_ch_minus = 1'b0;

    logic [7:0] a_cmd_out, b_cmd_out, a_drop, b_drop;
    logic       a_cmd_valid, b_cmd_valid, a_busy, b_busy;

`ifdef IR_CMD_REPEAT_EN
    localparam int REP_N = 4;
`else
    localparam int REP_N = 1;
`endif

    ir_cmd_scheduler #(.FIFO_DEPTH(4), .GAP_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .ir_cmd(ir_cmd), .ir_valid(ir_valid), .ir_repeat(ir_repeat),
        .btn_power(btn_power), .btn_ch_plus(btn_ch_plus), .btn_ch_minus(btn_ch_minus),
        .cmd_out(a_cmd_out), .cmd_valid(a_cmd_valid), .busy(a_busy), .drop_cnt(a_drop)
    );

    ir_cmd_scheduler #(.FIFO_DEPTH(4), .GAP_CYCLES(100)) dut_b (
        .clk(clk), .rst_n(rst_n), .ir_cmd(ir_cmd), .ir_valid(ir_valid), .ir_repeat(ir_repeat),
        .btn_power(btn_power), .btn_ch_plus(btn_ch_plus), .btn_ch_minus(btn_ch_minus),
        .cmd_out(b_cmd_out), .cmd_valid(b_cmd_valid), .busy(b_busy), .drop_cnt(b_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_a[$], exp_b[$];
    int         times_a[$], times_b[$];
    bit         mon_a_en = 1'b0, mon_b_en = 1'b0;
    logic [7:0] e_a, e_b;

    // Scoreboard: every strobe pops the oldest expected command.
    always @(negedge clk) begin
        if (rst_n && mon_a_en && a_cmd_valid) begin
            times_a.push_back(cyc);
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL sb_a_unexpected: cmd_out=%h strobed, none expected (cycle %0d)", a_cmd_out, cyc);
            end else begin
                e_a = exp_a.pop_front();
                if (a_cmd_out !== e_a) begin
                    errors++;
                    $display("FAIL sb_a_cmd: got %h expected %h (cycle %0d)", a_cmd_out, e_a, cyc);
                end
            end
        end
        if (rst_n && mon_b_en && b_cmd_valid) begin
            times_b.push_back(cyc);
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL sb_b_unexpected: cmd_out=%h strobed, none expected (cycle %0d)", b_cmd_out, cyc);
            end else begin
                e_b = exp_b.pop_front();
                if (b_cmd_out !== e_b) begin
                    errors++;
                    $display("FAIL sb_b_cmd: got %h expected %h (cycle %0d)", b_cmd_out, e_b, cyc);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ir_valid = 1'b0; ir_repeat = 1'b0; ir_cmd = 8'h00;
        btn_power = 1'b0; btn_ch_plus = 1'b0; btn_ch_minus = 1'b0;
        mon_a_en = 1'b0; mon_b_en = 1'b0;
        exp_a.delete(); exp_b.delete(); times_a.delete(); times_b.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic ir_pulse(input logic [7:0] code);
        ir_cmd = code; ir_valid = 1'b1;
        @(negedge clk);
        ir_valid = 1'b0;
    endtask

    task automatic rep_pulse();
        ir_repeat = 1'b1;
        @(negedge clk);
        ir_repeat = 1'b0;
    endtask

    task automatic wait_a(input int n, input int budget, input string name);
        int k = 0;
        while (times_a.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (times_a.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d strobes, required %0d", name, times_a.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (a_cmd_out !== 8'h00) begin errors++; $display("FAIL reset_cmd_out: got %h required 00", a_cmd_out); end
        if (a_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b required 0", a_cmd_valid); end
        if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", a_busy); end
        if (a_drop !== 8'h00) begin errors++; $display("FAIL reset_drop_cnt: got %h required 00", a_drop); end
        if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b required 0", b_busy); end
    endtask

    task automatic test_single();
        int t0, s;
        do_reset();
        mon_a_en = 1'b1;
        t0 = cyc;
        exp_a.push_back(8'h18);
        ir_pulse(8'h18);
        wait_a(1, 40, "single");
        if (times_a.size() >= 1) begin
            s = times_a[0];
            checks++;
            if (s !== t0 + 3) begin errors++; $display("FAIL single_latency: strobe at %0d required %0d", s, t0 + 3); end
            goto(s + 1);
            checks++;
            if (a_cmd_valid !== 1'b0) begin errors++; $display("FAIL single_width: cmd_valid=%b one cycle later, required 0", a_cmd_valid); end
            goto(s + 4);
            checks++;
            if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy_gap: busy=%b in last gap cycle, required 1", a_busy); end
            goto(s + 5);
            checks += 2;
            if (a_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: busy=%b after gap, required 0", a_busy); end
            if (a_cmd_out !== 8'h18) begin errors++; $display("FAIL single_hold: cmd_out=%h required 18", a_cmd_out); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes[3] = '{8'h18, 8'h18, 8'h38};
        do_reset();
        mon_a_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_a.push_back(codes[i]);
            ir_pulse(codes[i]);
            @(negedge clk);
        end
        wait_a(3, 60, "b2b");
        if (times_a.size() >= 3) begin
            checks += 2;
            if (times_a[1] - times_a[0] !== 6) begin errors++; $display("FAIL b2b_spacing1: got %0d required 6", times_a[1] - times_a[0]); end
            if (times_a[2] - times_a[1] !== 6) begin errors++; $display("FAIL b2b_spacing2: got %0d required 6", times_a[2] - times_a[1]); end
        end
        checks++;
        if (a_drop !== 8'h00) begin errors++; $display("FAIL b2b_drop: got %0d required 0", a_drop); end
    endtask

    task automatic test_priority();
        do_reset();
        mon_a_en = 1'b1;
        exp_a.push_back(8'h18);
        exp_a.push_back(8'h38);
        btn_ch_plus = 1'b1; ir_cmd = 8'h38; ir_valid = 1'b1;
        @(negedge clk);
        btn_ch_plus = 1'b0; ir_valid = 1'b0;
        wait_a(2, 40, "arb");
        checks++;
        if (a_drop !== 8'h00) begin errors++; $display("FAIL arb_drop: got %0d required 0", a_drop); end

        do_reset();
        mon_a_en = 1'b1;
        exp_a.push_back(8'h80);
        btn_power = 1'b1; btn_ch_minus = 1'b1;
        @(negedge clk);
        btn_power = 1'b0; btn_ch_minus = 1'b0;
        wait_a(1, 40, "prio");
        repeat (30) @(negedge clk);
        checks += 2;
        if (times_a.size() !== 1) begin errors++; $display("FAIL prio_count: got %0d strobes required 1", times_a.size()); end
        if (a_drop !== 8'h01) begin errors++; $display("FAIL prio_drop: got %0d required 1", a_drop); end
    endtask

    task automatic test_fifo_full();
        int t0, k;
        bit busy_bad = 1'b0;
        do_reset();
        mon_b_en = 1'b1;
        t0 = cyc;
        // Seventh request finds the IR pending register still holding the sixth.
        for (int i = 0; i < 7; i++) begin
            if (i < 6) exp_b.push_back(8'(i + 1));
            ir_pulse(8'(i + 1));
            if (b_busy !== 1'b1) busy_bad = 1'b1;
            @(negedge clk);
            if (b_busy !== 1'b1) busy_bad = 1'b1;
        end
        k = 0;
        while (times_b.size() < 6 && k < 800) begin
            @(negedge clk);
            if (b_busy !== 1'b1) busy_bad = 1'b1;
            k++;
        end
        checks++;
        if (times_b.size() < 6) begin
            errors++;
            $display("FAIL full_timeout: got %0d strobes required 6", times_b.size());
        end else begin
            checks++;
            if (times_b[5] !== t0 + 3 + 5 * 102) begin errors++; $display("FAIL full_last_time: got %0d required %0d", times_b[5], t0 + 3 + 510); end
            while (cyc < times_b[5] + 100) begin
                @(negedge clk);
                if (b_busy !== 1'b1) busy_bad = 1'b1;
            end
            @(negedge clk);
            checks += 2;
            if (busy_bad) begin errors++; $display("FAIL full_busy_hold: busy=0 seen before last gap end, required 1"); end
            if (b_busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b required 0", b_busy); end
        end
        repeat (20) @(negedge clk);
        checks += 2;
        if (b_drop !== 8'h01) begin errors++; $display("FAIL full_drop: got %0d required 1", b_drop); end
        if (times_b.size() !== 6) begin errors++; $display("FAIL full_count: got %0d required 6", times_b.size()); end
    endtask

    task automatic test_repeat();
        do_reset();
        mon_a_en = 1'b1;
        exp_a.push_back(8'h18);
        ir_pulse(8'h18);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (REP_N == 4) exp_a.push_back(8'h18);
            rep_pulse();
            repeat (20) @(negedge clk);
        end
        checks++;
        if (times_a.size() !== REP_N) begin errors++; $display("FAIL rep_chplus: got %0d strobes required %0d", times_a.size(), REP_N); end
        exp_a.push_back(8'h80);
        ir_pulse(8'h80);
        repeat (20) @(negedge clk);
        rep_pulse();
        repeat (20) @(negedge clk);
        checks += 2;
        if (times_a.size() !== REP_N + 1) begin errors++; $display("FAIL rep_power: got %0d strobes required %0d", times_a.size(), REP_N + 1); end
        if (a_drop !== 8'h00) begin errors++; $display("FAIL rep_drop: got %0d required 0", a_drop); end
    endtask

    task automatic test_reset_mid();
        int t0;
        do_reset();
        mon_a_en = 1'b1;
        t0 = cyc;
        exp_a.push_back(8'h11);
        ir_cmd = 8'h11; ir_valid = 1'b1;
        @(negedge clk);
        ir_valid = 1'b0; btn_ch_plus = 1'b1;
        @(negedge clk);
        btn_ch_plus = 1'b0; ir_cmd = 8'h22; ir_valid = 1'b1;
        @(negedge clk);
        ir_valid = 1'b0; btn_ch_minus = 1'b1;
        @(negedge clk);
        btn_ch_minus = 1'b0;
        goto(t0 + 6);
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b required 1", a_busy); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (a_cmd_out !== 8'h00) begin errors++; $display("FAIL midrst_cmd_out: got %h required 00", a_cmd_out); end
        if (a_cmd_valid !== 1'b0) begin errors++; $display("FAIL midrst_cmd_valid: got %b required 0", a_cmd_valid); end
        if (a_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", a_busy); end
        if (a_drop !== 8'h00) begin errors++; $display("FAIL midrst_drop: got %0d required 0", a_drop); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks += 3;
        if (times_a.size() !== 1) begin errors++; $display("FAIL midrst_strobes: got %0d strobes required 1", times_a.size()); end
        if (exp_a.size() !== 0) begin errors++; $display("FAIL midrst_pending_exp: %0d expected commands left, required 0", exp_a.size()); end
        if (a_drop !== 8'h00) begin errors++; $display("FAIL midrst_drop_after: got %0d required 0", a_drop); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_priority();
        test_fifo_full();
        test_repeat();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
